warp_reconv_stack: RTL and testbench
====================================

# warp_reconv_stack

SIMT divergence/reconvergence stack that drives the `warp_mask` update port. It sits between branch resolution and `warp_mask`, and it decides when and how the lane-enable mask changes. On a divergent branch it narrows the active mask to the taken lanes and saves the other paths. When the warp reaches the reconvergence PC it restores the saved masks and issues fetch redirects.

## Interface
- `NUM_LANES`, default 8: lanes per warp; width of every mask.
- `PC_WIDTH`, default 16: width of every PC field.
- `STACK_DEPTH`, default 4: number of stack entries, minimum 2.
- `DEPTH_W`, default $clog2(STACK_DEPTH+1): width of `depth`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `branch_valid`  in  1  a resolved branch is presented.
- `branch_ready`  out  1  combinational; the branch is accepted when `branch_valid & branch_ready`.
- `branch_taken`  in  NUM_LANES  per-lane taken predicate.
- `branch_target`  in  PC_WIDTH  taken-path PC.
- `branch_fallthru`  in  PC_WIDTH  not-taken-path PC.
- `branch_reconv`  in  PC_WIDTH  reconvergence PC (immediate post-dominator).
- `pc_valid`  in  1  `cur_pc` is valid this cycle.
- `cur_pc`  in  PC_WIDTH  PC the warp is currently issuing.
- `mask_update`  out  1  one-cycle pulse; connects to `warp_mask.mask_update`.
- `mask_in`  out  NUM_LANES  new mask; connects to `warp_mask.mask_in`.
- `active_mask`  out  NUM_LANES  current mask as held by this block.
- `redirect_valid`  out  1  one-cycle pulse requesting a fetch redirect.
- `redirect_pc`  out  PC_WIDTH  redirect target.
- `depth`  out  DEPTH_W  number of occupied stack entries.
- `stack_overflow`  out  1  sticky; cleared only by reset.

## Operation
- Each stack entry holds {kind, pc, rpc, mask}. `kind` is either PENDING or RECONV.
- Reset values: `active_mask` all ones; `depth` 0; `mask_in` all ones; `mask_update`, `redirect_valid`, `stack_overflow` and `holdoff` all 0; `redirect_pc` 0.
- Reconvergence hit (`hit`): `pc_valid & depth!=0 & ~holdoff & cur_pc==top.rpc`.
- `branch_ready = ~hit`. A hit has priority; a branch held off by it waits.
- Pop on `hit`:
  - `active_mask` becomes `top.mask`, `depth` decrements, and `mask_update` pulses.
  - If `top.kind` is PENDING: `redirect_valid` pulses with `redirect_pc = top.pc`, and `holdoff` is set.
  - If `top.kind` is RECONV: no redirect. A chain of same-rpc RECONV entries pops on consecutive cycles.
- `holdoff` clears on the first cycle with `pc_valid & cur_pc != rpc` of the popped entry.
- On an accepted branch, compute `T = branch_taken & active_mask` and `N = active_mask & ~branch_taken`.
  - `T==0`: no state change and no outputs.
  - `N==0`: redirect to `branch_target`; mask unchanged; no `mask_update`.
  - Divergent branch: needs `need` free slots, where `need = 1` if `branch_fallthru==branch_reconv`, else 2.
    - Push RECONV {rpc=`branch_reconv`, mask=`active_mask`}.
    - If `need==2`, then push PENDING {pc=`branch_fallthru`, rpc=`branch_reconv`, mask=N} on top of it.
    - `active_mask` becomes T; `mask_update` pulses; redirect to `branch_target`.
  - Divergent branch with fewer than `need` free slots: the branch is still accepted. Set `stack_overflow`, change no state, assert no outputs.
- `mask_in` always equals the `active_mask` value being committed.
- The block is always the sole writer of `warp_mask`, so `warp_mask.mask_out` tracks `active_mask` one cycle later.

## Timing
- All outputs except `branch_ready` are registered.
- An event accepted or hit at edge k produces `mask_update`, `mask_in`, `active_mask`, `redirect_valid` and `redirect_pc` valid in cycle k+1, for exactly one cycle.
- `warp_mask` captures at edge k+1, giving an end-to-end latency of 2 edges.
- Back-to-back events are accepted every cycle; each event's pulses do not merge with the next event's.
- `depth` updates in the same cycle as `mask_update`.
- Reset asserted mid-operation returns every register to its reset value asynchronously; pulses in flight are dropped.

## Test plan
- Reset, then idle 5 cycles -> `active_mask`=0xFF, `depth`=0, no pulses; `warp_mask` reads 0xFF.
- Branch `taken`=0x0F, target=0x20, fallthru=0x11, reconv=0x30 -> next cycle `mask_in`=0x0F, `redirect_pc`=0x20, `depth`=2.
  - Then `cur_pc`=0x30 -> `mask_in`=0xF0, redirect 0x11, `depth`=1.
  - `cur_pc`=0x30 again only after a pc≠0x30 -> `mask_in`=0xFF, no redirect, `depth`=0.
- Uniform branches: `taken`=0xFF -> redirect only, no `mask_update`; `taken`=0x00 -> no outputs at all.
- fallthru==reconv=0x30, `taken`=0x03 -> `depth`=1, `mask_in`=0x03; `cur_pc`=0x30 -> `mask_in`=0xFF, no redirect.
- Nested divergence with `STACK_DEPTH`=4: two 2-slot divergent branches fill the stack to `depth`=4.
  - A third divergent branch -> `stack_overflow`=1 and mask unchanged.
  - `hit` and `branch_valid` in the same cycle -> `branch_ready`=0 and the pop is performed.
- Assert reset with `depth`=3 -> `depth`=0, `active_mask`=0xFF, `stack_overflow`=0 immediately.

Source files
------------

// File: rtl/warp_reconv_stack.sv
// -----------------------------------------------------------------------------
// warp_reconv_stack
//
// SIMT divergence/reconvergence stack. Sits between branch resolution and the
// warp_mask block and is the sole writer of the lane-enable mask. A divergent
// branch narrows the active mask to the taken lanes and saves the remaining
// paths on a stack. When the warp reaches a saved reconvergence PC, the saved
// mask is restored and, for a pending path, a fetch redirect is issued.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   branch_valid      a resolved branch is presented
//   branch_ready      combinational; low while a reconvergence hit is popping
//   branch_taken      per-lane taken predicate
//   branch_target     taken-path PC
//   branch_fallthru   not-taken-path PC
//   branch_reconv     reconvergence PC (immediate post-dominator)
//   pc_valid, cur_pc  PC the warp is currently issuing
//   mask_update       one-cycle pulse to warp_mask.mask_update
//   mask_in           mask being committed, to warp_mask.mask_in
//   active_mask       current mask held by this block
//   redirect_valid    one-cycle fetch-redirect pulse
//   redirect_pc       redirect target
//   depth             occupied stack entries
//   stack_overflow    sticky overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module warp_reconv_stack #(
    parameter int NUM_LANES   = 8,
    parameter int PC_WIDTH    = 16,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 branch_valid,
    output logic                 branch_ready,
    input  logic [NUM_LANES-1:0] branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic [PC_WIDTH-1:0]  branch_fallthru,
    input  logic [PC_WIDTH-1:0]  branch_reconv,
    input  logic                 pc_valid,
    input  logic [PC_WIDTH-1:0]  cur_pc,
    output logic                 mask_update,
    output logic [NUM_LANES-1:0] mask_in,
    output logic [NUM_LANES-1:0] active_mask,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [DEPTH_W-1:0]   depth,
    output logic                 stack_overflow
);

    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic KIND_PENDING = 1'b0;
    localparam logic KIND_RECONV  = 1'b1;

    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1'b1);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2'd2);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    // Stack storage
    logic                 kind_r [STACK_DEPTH];
    logic [PC_WIDTH-1:0]  pc_r   [STACK_DEPTH];
    logic [PC_WIDTH-1:0]  rpc_r  [STACK_DEPTH];
    logic [NUM_LANES-1:0] mask_r [STACK_DEPTH];

    // Architectural and output registers
    logic [NUM_LANES-1:0] active_mask_r;
    logic [DEPTH_W-1:0]   depth_r;
    logic                 mask_update_r;
    logic [NUM_LANES-1:0] mask_in_r;
    logic                 redirect_valid_r;
    logic [PC_WIDTH-1:0]  redirect_pc_r;
    logic                 overflow_r;
    logic                 holdoff_r;
    logic [PC_WIDTH-1:0]  holdoff_rpc_r;

    // Next-state values
    logic [NUM_LANES-1:0] active_mask_s;
    logic [DEPTH_W-1:0]   depth_s;
    logic                 mask_update_s;
    logic                 redirect_valid_s;
    logic [PC_WIDTH-1:0]  redirect_pc_s;
    logic                 overflow_s;
    logic                 holdoff_s;
    logic [PC_WIDTH-1:0]  holdoff_rpc_s;

    // Top-of-stack view and decode helpers
    logic [IDX_W-1:0]     top_idx_s;
    logic                 top_kind_s;
    logic [PC_WIDTH-1:0]  top_pc_s;
    logic [PC_WIDTH-1:0]  top_rpc_s;
    logic [NUM_LANES-1:0] top_mask_s;
    logic                 hit_s;
    logic [NUM_LANES-1:0] taken_s;
    logic [NUM_LANES-1:0] not_taken_s;
    logic [DEPTH_W-1:0]   need_s;
    logic [DEPTH_W-1:0]   free_s;
    logic [IDX_W-1:0]     push_lo_idx_s;
    logic [IDX_W-1:0]     push_hi_idx_s;
    logic                 push_lo_s;
    logic                 push_hi_s;

    // Top-of-stack read, reconvergence hit detect and branch decode
    always_comb begin
        top_idx_s     = IDX_W'(depth_r - DEPTH_ONE);
        top_kind_s    = kind_r[top_idx_s];
        top_pc_s      = pc_r[top_idx_s];
        top_rpc_s     = rpc_r[top_idx_s];
        top_mask_s    = mask_r[top_idx_s];
        // holdoff keeps a just-popped PENDING path from immediately popping
        // the same-rpc entry below it while fetch still shows the old PC.
        hit_s         = pc_valid && (depth_r != DEPTH_ZERO) && !holdoff_r &&
                        (cur_pc == top_rpc_s);
        taken_s       = branch_taken & active_mask_r;
        not_taken_s   = active_mask_r & ~branch_taken;
        // When the fall-through path is the reconvergence point, there is no
        // separate pending path to save.
        need_s        = (branch_fallthru == branch_reconv) ? DEPTH_ONE : DEPTH_TWO;
        free_s        = DEPTH_FULL - depth_r;
        push_lo_idx_s = IDX_W'(depth_r);
        push_hi_idx_s = IDX_W'(depth_r + DEPTH_ONE);
    end

    assign branch_ready = ~hit_s;

    // Next-state selection: pop on hit, otherwise process an accepted branch
    always_comb begin
        active_mask_s    = active_mask_r;
        depth_s          = depth_r;
        mask_update_s    = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = redirect_pc_r;
        overflow_s       = overflow_r;
        holdoff_rpc_s    = holdoff_rpc_r;
        push_lo_s        = 1'b0;
        push_hi_s        = 1'b0;

        if (holdoff_r && pc_valid && (cur_pc != holdoff_rpc_r)) begin
            holdoff_s = 1'b0;
        end else begin
            holdoff_s = holdoff_r;
        end

        if (hit_s) begin
            active_mask_s = top_mask_s;
            depth_s       = depth_r - DEPTH_ONE;
            mask_update_s = 1'b1;
            if (top_kind_s == KIND_PENDING) begin
                redirect_valid_s = 1'b1;
                redirect_pc_s    = top_pc_s;
                holdoff_s        = 1'b1;
                holdoff_rpc_s    = top_rpc_s;
            end else begin
                redirect_valid_s = 1'b0;
            end
        end else if (branch_valid) begin
            if (taken_s == {NUM_LANES{1'b0}}) begin
                // No active lane takes the branch: nothing changes.
                redirect_valid_s = 1'b0;
            end else if (not_taken_s == {NUM_LANES{1'b0}}) begin
                // Uniformly taken: redirect only, mask unchanged.
                redirect_valid_s = 1'b1;
                redirect_pc_s    = branch_target;
            end else if (free_s < need_s) begin
                // Branch is consumed but cannot be tracked.
                overflow_s = 1'b1;
            end else begin
                push_lo_s        = 1'b1;
                push_hi_s        = (need_s == DEPTH_TWO);
                depth_s          = depth_r + need_s;
                active_mask_s    = taken_s;
                mask_update_s    = 1'b1;
                redirect_valid_s = 1'b1;
                redirect_pc_s    = branch_target;
            end
        end else begin
            redirect_valid_s = 1'b0;
        end
    end

    // Architectural state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_mask_r    <= {NUM_LANES{1'b1}};
            depth_r          <= DEPTH_ZERO;
            mask_update_r    <= 1'b0;
            mask_in_r        <= {NUM_LANES{1'b1}};
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {PC_WIDTH{1'b0}};
            overflow_r       <= 1'b0;
            holdoff_r        <= 1'b0;
            holdoff_rpc_r    <= {PC_WIDTH{1'b0}};
        end else begin
            active_mask_r    <= active_mask_s;
            depth_r          <= depth_s;
            mask_update_r    <= mask_update_s;
            mask_in_r        <= active_mask_s;
            redirect_valid_r <= redirect_valid_s;
            redirect_pc_r    <= redirect_pc_s;
            overflow_r       <= overflow_s;
            holdoff_r        <= holdoff_s;
            holdoff_rpc_r    <= holdoff_rpc_s;
        end
    end

    // Stack entry writes: RECONV entry below, PENDING entry on top of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                kind_r[i] <= KIND_PENDING;
                pc_r[i]   <= {PC_WIDTH{1'b0}};
                rpc_r[i]  <= {PC_WIDTH{1'b0}};
                mask_r[i] <= {NUM_LANES{1'b0}};
            end
        end else begin
            if (push_lo_s) begin
                kind_r[push_lo_idx_s] <= KIND_RECONV;
                pc_r[push_lo_idx_s]   <= branch_reconv;
                rpc_r[push_lo_idx_s]  <= branch_reconv;
                mask_r[push_lo_idx_s] <= active_mask_r;
            end
            if (push_hi_s) begin
                kind_r[push_hi_idx_s] <= KIND_PENDING;
                pc_r[push_hi_idx_s]   <= branch_fallthru;
                rpc_r[push_hi_idx_s]  <= branch_reconv;
                mask_r[push_hi_idx_s] <= not_taken_s;
            end
        end
    end

    assign active_mask    = active_mask_r;
    assign depth          = depth_r;
    assign mask_update    = mask_update_r;
    assign mask_in        = mask_in_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign stack_overflow = overflow_r;

endmodule

// File: tb/tb_warp_reconv_stack.sv
// -----------------------------------------------------------------------------
// tb_warp_reconv_stack
//
// Directed, table-driven bench for warp_reconv_stack with default parameters
// (8 lanes, 16-bit PCs, 4 entries). Each table row gives the inputs for one
// cycle and the outputs expected one edge later; branch_ready is checked
// combinationally before the edge. A hand sequence covers reset mid-operation.
// -----------------------------------------------------------------------------
module tb_warp_reconv_stack;

    logic        clk;
    logic        rst_n;
    logic        branch_valid;
    logic        branch_ready;
    logic [7:0]  branch_taken;
    logic [15:0] branch_target;
    logic [15:0] branch_fallthru;
    logic [15:0] branch_reconv;
    logic        pc_valid;
    logic [15:0] cur_pc;
    logic        mask_update;
    logic [7:0]  mask_in;
    logic [7:0]  active_mask;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [2:0]  depth;
    logic        stack_overflow;

    int n_checks;
    int n_fail;

    warp_reconv_stack dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .branch_valid    (branch_valid),
        .branch_ready    (branch_ready),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .branch_fallthru (branch_fallthru),
        .branch_reconv   (branch_reconv),
        .pc_valid        (pc_valid),
        .cur_pc          (cur_pc),
        .mask_update     (mask_update),
        .mask_in         (mask_in),
        .active_mask     (active_mask),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .depth           (depth),
        .stack_overflow  (stack_overflow)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        bv;
        logic [7:0]  taken;
        logic [15:0] tgt;
        logic [15:0] ft;
        logic [15:0] rc;
        logic        pv;
        logic [15:0] cur;
        logic        rdy;
        logic        mu;
        logic [7:0]  mi;
        logic [7:0]  am;
        logic        rv;
        logic [15:0] rpc;
        logic [2:0]  d;
        logic        ov;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", nm, row, act, exp);
        end
    endtask

    task automatic chk_reset_state(input int tag);
        chk("rst.active_mask", tag, 32'(active_mask), 32'h0000_00FF);
        chk("rst.mask_in", tag, 32'(mask_in), 32'h0000_00FF);
        chk("rst.depth", tag, 32'(depth), 32'h0000_0000);
        chk("rst.mask_update", tag, 32'(mask_update), 32'h0000_0000);
        chk("rst.redirect_valid", tag, 32'(redirect_valid), 32'h0000_0000);
        chk("rst.redirect_pc", tag, 32'(redirect_pc), 32'h0000_0000);
        chk("rst.stack_overflow", tag, 32'(stack_overflow), 32'h0000_0000);
    endtask

    task automatic drive_idle();
        branch_valid    = 1'b0;
        branch_taken    = 8'h00;
        branch_target   = 16'h0000;
        branch_fallthru = 16'h0000;
        branch_reconv   = 16'h0000;
        pc_valid        = 1'b0;
        cur_pc          = 16'h0000;
    endtask

    // Called just after a rising edge: drive, check ready, clock, check outputs.
    task automatic apply_row(input int r);
        branch_valid    = vecs[r].bv;
        branch_taken    = vecs[r].taken;
        branch_target   = vecs[r].tgt;
        branch_fallthru = vecs[r].ft;
        branch_reconv   = vecs[r].rc;
        pc_valid        = vecs[r].pv;
        cur_pc          = vecs[r].cur;
        #1;
        chk("branch_ready", r, 32'(branch_ready), 32'(vecs[r].rdy));
        @(posedge clk);
        #1;
        chk("mask_update", r, 32'(mask_update), 32'(vecs[r].mu));
        chk("mask_in", r, 32'(mask_in), 32'(vecs[r].mi));
        chk("active_mask", r, 32'(active_mask), 32'(vecs[r].am));
        chk("redirect_valid", r, 32'(redirect_valid), 32'(vecs[r].rv));
        chk("redirect_pc", r, 32'(redirect_pc), 32'(vecs[r].rpc));
        chk("depth", r, 32'(depth), 32'(vecs[r].d));
        chk("stack_overflow", r, 32'(stack_overflow), 32'(vecs[r].ov));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //          bv    taken  tgt       ft        rc        pv    cur        rdy   mu    mi     am     rv    rpc       d     ov
        vecs[0]  = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 16'h0000, 3'd0, 1'b0};
        // divergent branch, two entries pushed
        vecs[2]  = '{1'b1, 8'h0F, 16'h0020, 16'h0011, 16'h0030, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h0F, 8'h0F, 1'b1, 16'h0020, 3'd2, 1'b0};
        // reach reconv: pop PENDING, redirect to fall-through
        vecs[3]  = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b0, 1'b1, 8'hF0, 8'hF0, 1'b1, 16'h0011, 3'd1, 1'b0};
        // same PC again: held off
        vecs[4]  = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b1, 1'b0, 8'hF0, 8'hF0, 1'b0, 16'h0011, 3'd1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0011, 1'b1, 1'b0, 8'hF0, 8'hF0, 1'b0, 16'h0011, 3'd1, 1'b0};
        // back at reconv: pop RECONV, full mask, no redirect
        vecs[6]  = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 16'h0011, 3'd0, 1'b0};
        // uniform taken / uniform not-taken
        vecs[7]  = '{1'b1, 8'hFF, 16'h0040, 16'h0041, 16'h0050, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 16'h0040, 3'd0, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 16'h0060, 16'h0061, 16'h0070, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 16'h0040, 3'd0, 1'b0};
        // fallthru == reconv: one entry
        vecs[9]  = '{1'b1, 8'h03, 16'h0020, 16'h0030, 16'h0030, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h03, 8'h03, 1'b1, 16'h0020, 3'd1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 16'h0020, 3'd0, 1'b0};
        // nested divergence fills the stack
        vecs[11] = '{1'b1, 8'h0F, 16'h0100, 16'h0101, 16'h0200, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h0F, 8'h0F, 1'b1, 16'h0100, 3'd2, 1'b0};
        vecs[12] = '{1'b1, 8'h03, 16'h0110, 16'h0111, 16'h0120, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h03, 8'h03, 1'b1, 16'h0110, 3'd4, 1'b0};
        // third divergent branch: overflow, nothing else
        vecs[13] = '{1'b1, 8'h01, 16'h0130, 16'h0131, 16'h0140, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 16'h0110, 3'd4, 1'b1};
        // hit and branch together: pop wins, ready low
        vecs[14] = '{1'b1, 8'h01, 16'h0130, 16'h0131, 16'h0140, 1'b1, 16'h0120, 1'b0, 1'b1, 8'h0C, 8'h0C, 1'b1, 16'h0111, 3'd3, 1'b1};
        // one free slot, two needed: overflow, no change
        vecs[15] = '{1'b1, 8'h04, 16'h0150, 16'h0151, 16'h0160, 1'b1, 16'h0120, 1'b1, 1'b0, 8'h0C, 8'h0C, 1'b0, 16'h0111, 3'd3, 1'b1};
        // one free slot, one needed: accepted, stack full again
        vecs[16] = '{1'b1, 8'h04, 16'h0150, 16'h0160, 16'h0160, 1'b1, 16'h0112, 1'b1, 1'b1, 8'h04, 8'h04, 1'b1, 16'h0150, 3'd4, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0160, 1'b0, 1'b1, 8'h0C, 8'h0C, 1'b0, 16'h0150, 3'd3, 1'b1};
        // after reset: two same-rpc RECONV entries pop on consecutive cycles
        vecs[18] = '{1'b1, 8'h0F, 16'h0020, 16'h0030, 16'h0030, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h0F, 8'h0F, 1'b1, 16'h0020, 3'd1, 1'b0};
        vecs[19] = '{1'b1, 8'h03, 16'h0021, 16'h0030, 16'h0030, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h03, 8'h03, 1'b1, 16'h0021, 3'd2, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b0, 1'b1, 8'h0F, 8'h0F, 1'b0, 16'h0021, 3'd1, 1'b0};
        vecs[21] = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 16'h0021, 3'd0, 1'b0};
        vecs[22] = '{1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0030, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 16'h0021, 3'd0, 1'b0};

        // Power-on reset
        rst_n = 1'b0;
        drive_idle();
        #12;
        chk_reset_state(-1);
        chk("rst.branch_ready", -1, 32'(branch_ready), 32'h0000_0001);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle cycles, then the main table
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
        end
        #1;
        for (int r = 0; r <= 17; r++) begin
            apply_row(r);
        end

        // Reset mid-operation with depth 3: immediate return to reset values
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state(-2);
        @(posedge clk);
        #1;
        chk_reset_state(-3);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state(-4);

        for (int r = 18; r <= 22; r++) begin
            apply_row(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
